// File: rtl/square_wave_gen_prog.sv
// Programmable square-wave source for the DAC data bus. Period, duty and amplitudes
// come in through a valid/ready shadow register and take effect only at a period boundary.
module square_wave_gen_prog #(
    parameter int DATA_W        = 10,
    parameter int CNT_W         = 16,
    parameter int RST_PERIOD_M1 = 255,
    parameter int RST_DUTY      = 128
) (
    input  logic              DAC_clk,
    input  logic              DAC_rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W:0]    cfg_duty,
    input  logic [DATA_W-1:0] cfg_amp_hi,
    input  logic [DATA_W-1:0] cfg_amp_lo,
    output logic [DATA_W-1:0] DAC_data,
    output logic              sync
);

    typedef enum logic {IDLE, PEND} cfg_state_t;

    cfg_state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_m1, sh_period;
    logic [CNT_W:0]    duty, sh_duty;
    logic [DATA_W-1:0] amp_hi, amp_lo, sh_amp_hi, sh_amp_lo;

    logic at_end;
    logic high;
    logic accept;
    logic apply;

    // Using >= rather than == keeps the counter from overrunning a shortened period.
    assign at_end = (cnt >= period_m1);
    assign high   = ({1'b0, cnt} < duty);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        apply      = 1'b0;
        cfg_ready  = (state == IDLE);
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    accept     = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (!en || at_end) begin
                    apply      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge DAC_clk) begin
        if (!DAC_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge DAC_clk) begin
        if (!DAC_rst_n) begin
            sh_period <= '0;
            sh_duty   <= '0;
            sh_amp_hi <= '0;
            sh_amp_lo <= '0;
        end else if (accept) begin
            sh_period <= cfg_period;
            sh_duty   <= cfg_duty;
            sh_amp_hi <= cfg_amp_hi;
            sh_amp_lo <= cfg_amp_lo;
        end
    end

    // Active settings only move on a wrap or while stopped, so no runt pulses.
    always_ff @(posedge DAC_clk) begin
        if (!DAC_rst_n) begin
            period_m1 <= CNT_W'(RST_PERIOD_M1);
            duty      <= (CNT_W+1)'(RST_DUTY);
            amp_hi    <= '1;
            amp_lo    <= '0;
        end else if (apply) begin
            period_m1 <= sh_period;
            duty      <= sh_duty;
            amp_hi    <= sh_amp_hi;
            amp_lo    <= sh_amp_lo;
        end
    end

    always_ff @(posedge DAC_clk) begin
        if (!DAC_rst_n) begin
            cnt <= '0;
        end else if (!en || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge DAC_clk) begin
        if (!DAC_rst_n) begin
            DAC_data <= '0;
            sync     <= 1'b0;
        end else begin
            DAC_data <= (en && high) ? amp_hi : amp_lo;
            sync     <= en && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_square_wave_gen_prog.sv
// Directed bench for square_wave_gen_prog: default wave, mid-period reconfig, saturation
// cases, wrap-edge accept, enable gating and reset with a pending configuration.
module tb_square_wave_gen_prog;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 16;

    logic              DAC_clk = 1'b0;
    logic              DAC_rst_n;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W:0]    cfg_duty;
    logic [DATA_W-1:0] cfg_amp_hi;
    logic [DATA_W-1:0] cfg_amp_lo;
    logic [DATA_W-1:0] DAC_data;
    logic              sync;

    int errors = 0;
    int checks = 0;

    square_wave_gen_prog dut (
        .DAC_clk    (DAC_clk),
        .DAC_rst_n  (DAC_rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_amp_hi (cfg_amp_hi),
        .cfg_amp_lo (cfg_amp_lo),
        .DAC_data   (DAC_data),
        .sync       (sync)
    );

    always #5 DAC_clk = ~DAC_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge DAC_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [CNT_W-1:0] p, input logic [CNT_W:0] d,
                                 input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
        cfg_period = p;
        cfg_duty   = d;
        cfg_amp_hi = hi;
        cfg_amp_lo = lo;
        cfg_valid  = 1'b1;
    endtask

    // Offers one config, then steps until the apply edge; afterwards cnt is 0.
    task automatic load_cfg(input string tag, input logic [CNT_W-1:0] p, input logic [CNT_W:0] d,
                            input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
        int n;
        applyStimulus(p, d, hi, lo);
        step();
        cfg_valid = 1'b0;
        checkOutput({tag, "_ready_low"}, 32'(cfg_ready), 32'd0);
        n = 0;
        while (!cfg_ready && n < 600) begin
            step();
            n++;
        end
        checkOutput({tag, "_ready_back"}, 32'(cfg_ready), 32'd1);
    endtask

    // Runs n edges starting from cnt==0 and checks the expected hi/lo/sync sequence.
    task automatic check_run(input string tag, input int n, input int per, input int hi_cycles,
                             input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
        int bad;
        logic [DATA_W-1:0] exp_data;
        logic exp_sync;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step();
            exp_data = ((i % per) < hi_cycles) ? hi : lo;
            exp_sync = ((i % per) == 0);
            if (DAC_data !== exp_data || sync !== exp_sync) bad++;
        end
        checkOutput({tag, "_bad_samples"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        DAC_rst_n  = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_duty   = '0;
        cfg_amp_hi = '0;
        cfg_amp_lo = '0;
        step();
        step();
        checkOutput("rst_data", 32'(DAC_data), 32'h0);
        checkOutput("rst_sync", 32'(sync), 32'd0);
        checkOutput("rst_ready", 32'(cfg_ready), 32'd1);

        // Default 256-cycle wave, 128 high samples first; run 4 edges into the second period.
        DAC_rst_n = 1'b1;
        en        = 1'b1;
        check_run("t1_default", 260, 256, 128, 10'h3FF, 10'h000);

        // Mid-period config; a second offer while pending must be ignored.
        applyStimulus(16'd9, 17'd3, 10'h200, 10'h010);
        step();
        checkOutput("t2_ready_after_accept", 32'(cfg_ready), 32'd0);
        applyStimulus(16'd5, 17'd1, 10'h3C3, 10'h3C3);
        step();
        cfg_valid = 1'b0;
        checkOutput("t2_ready_held", 32'(cfg_ready), 32'd0);
        repeat (249) step();
        checkOutput("t2_ready_before_wrap", 32'(cfg_ready), 32'd0);
        checkOutput("t2_old_low", 32'(DAC_data), 32'h000);
        step();
        checkOutput("t2_ready_at_wrap", 32'(cfg_ready), 32'd1);
        checkOutput("t2_wrap_data", 32'(DAC_data), 32'h000);
        checkOutput("t2_wrap_sync", 32'(sync), 32'd0);
        check_run("t2_pattern", 20, 10, 3, 10'h200, 10'h010);

        // Saturation cases.
        load_cfg("t3a", 16'd9, 17'd0, 10'h200, 10'h010);
        check_run("t3a_duty0", 12, 10, 0, 10'h200, 10'h010);
        load_cfg("t3b", 16'd9, 17'd11, 10'h200, 10'h010);
        check_run("t3b_duty_gt", 12, 10, 10, 10'h200, 10'h010);
        load_cfg("t3c", 16'd0, 17'd1, 10'h3AA, 10'h055);
        check_run("t3c_period0", 8, 1, 1, 10'h3AA, 10'h055);

        // Accept on the wrap edge: old settings get one more full period.
        load_cfg("t5", 16'd3, 17'd2, 10'h300, 10'h0C0);
        check_run("t5_pre", 3, 4, 2, 10'h300, 10'h0C0);
        applyStimulus(16'd1, 17'd1, 10'h111, 10'h022);
        step();
        cfg_valid = 1'b0;
        checkOutput("t5_wrap_accept_data", 32'(DAC_data), 32'h0C0);
        checkOutput("t5_wrap_accept_ready", 32'(cfg_ready), 32'd0);
        check_run("t5_old", 4, 4, 2, 10'h300, 10'h0C0);
        checkOutput("t5_applied_ready", 32'(cfg_ready), 32'd1);
        check_run("t5_new", 4, 2, 1, 10'h111, 10'h022);

        // Config while disabled applies on the next edge.
        en = 1'b0;
        applyStimulus(16'd4, 17'd2, 10'h2F0, 10'h00F);
        step();
        cfg_valid = 1'b0;
        checkOutput("t4_accept_ready", 32'(cfg_ready), 32'd0);
        checkOutput("t4_accept_data", 32'(DAC_data), 32'h022);
        checkOutput("t4_accept_sync", 32'(sync), 32'd0);
        step();
        checkOutput("t4_apply_ready", 32'(cfg_ready), 32'd1);
        checkOutput("t4_apply_data", 32'(DAC_data), 32'h022);
        step();
        checkOutput("t4_idle_data", 32'(DAC_data), 32'h00F);
        checkOutput("t4_idle_sync", 32'(sync), 32'd0);
        en = 1'b1;
        check_run("t4_resume", 5, 5, 2, 10'h2F0, 10'h00F);

        // Reset in the high phase with a pending config and a same-edge offer.
        applyStimulus(16'd7, 17'd7, 10'h155, 10'h2AA);
        step();
        checkOutput("t6_pending_ready", 32'(cfg_ready), 32'd0);
        checkOutput("t6_high_data", 32'(DAC_data), 32'h2F0);
        applyStimulus(16'd2, 17'd1, 10'h0AA, 10'h1FF);
        DAC_rst_n = 1'b0;
        step();
        cfg_valid = 1'b0;
        checkOutput("t6_rst_data", 32'(DAC_data), 32'h0);
        checkOutput("t6_rst_sync", 32'(sync), 32'd0);
        checkOutput("t6_rst_ready", 32'(cfg_ready), 32'd1);
        DAC_rst_n = 1'b1;
        check_run("t6_default", 257, 256, 128, 10'h3FF, 10'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
